// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit, one bit per clock, results in HI/LO.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divByZero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic r_div, r_neg, r_neg_r, r_busy, r_done, r_dz;
  logic [WIDTH-1:0] r_b, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_rem, w_q, w_r, w_hi, w_lo;
  logic [WIDTH:0] w_sum, w_sh;
  logic [2*WIDTH-1:0] w_mul_nx, w_div_nx, w_prod;
  logic w_ge, w_dz;
  assign w_abs_a = (op[0] && a[WIDTH-1]) ? -a : a;
  assign w_abs_b = (op[0] && b[WIDTH-1]) ? -b : b;
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_nx = {w_sum, r_acc[WIDTH-1:1]};
  assign w_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge = w_sh >= {1'b0, r_b};
  assign w_rem = w_ge ? WIDTH'(w_sh - {1'b0, r_b}) : w_sh[WIDTH-1:0];
  assign w_div_nx = {w_rem, r_acc[WIDTH-2:0], w_ge};
  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_q = r_acc[WIDTH-1:0];
  assign w_r = r_acc[2*WIDTH-1:WIDTH];
  // With a zero divisor every step subtracts nothing, so the remainder ends as |a|
  assign w_dz = r_div && (r_b == '0);
  assign w_lo = r_div ? (w_dz ? '1 : (r_neg ? -w_q : w_q)) : w_prod[WIDTH-1:0];
  assign w_hi = r_div ? (r_neg_r ? -w_r : w_r) : w_prod[2*WIDTH-1:WIDTH];
  always_comb begin
    w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
             (r_state == RUN) ? ((r_cnt == '0) ? FIN : RUN) : IDLE;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_hi <= '0;
      r_lo <= '0;
      r_dz <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy <= (w_next != IDLE);
      r_done <= (r_state == FIN);
      if (r_state == IDLE && start) r_dz <= 1'b0;
      if (r_state == FIN) begin
        r_hi <= w_hi;
        r_lo <= w_lo;
        r_dz <= w_dz;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (r_state == IDLE && start) begin
      r_div <= op[1];
      r_neg <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
      r_neg_r <= op[0] & op[1] & a[WIDTH-1];
      r_b <= w_abs_b;
      r_acc <= {{WIDTH{1'b0}}, w_abs_a};
      r_cnt <= CW'(WIDTH - 1);
    end else if (r_state == RUN) begin
      r_acc <= r_div ? w_div_nx : w_mul_nx;
      r_cnt <= r_cnt - CW'(1);
    end
  end
  assign busy = r_busy;
  assign done = r_done;
  assign hi = r_hi;
  assign lo = r_lo;
  assign divByZero = r_dz;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table-driven scoreboard bench for mult_div_unit at WIDTH 32 and 8.
module tb_mult_div_unit;
  localparam int W = 32;
  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;
  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] hi;
    logic [7:0] lo;
  } v8_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, start, busy, done, dz, start8, busy8, done8, dz8;
  logic [1:0] op, op8;
  logic [W-1:0] a, b, hi, lo;
  logic [7:0] a8, b8, hi8, lo8;
  vec_t vecs[$];
  vec_t sb[$];
  v8_t t8[3];
  int n_chk = 0;
  int n_fail = 0;
  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clk), .reset(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .divByZero(dz)
  );
  mult_div_unit #(.WIDTH(8)) dut8 (
    .clock(clk), .reset(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .divByZero(dz8)
  );
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    vec_t v;
    longint sx, sy;
    logic [63:0] p, q, r;
    v.op = o; v.a = x; v.b = y; v.dz = 1'b0;
    sx = o[0] ? longint'($signed(x)) : longint'({32'b0, x});
    sy = o[0] ? longint'($signed(y)) : longint'({32'b0, y});
    if (!o[1]) begin
      p = sx * sy;
      v.hi = p[63:32]; v.lo = p[31:0];
    end else if (y == '0) begin
      v.hi = x; v.lo = '1; v.dz = 1'b1;
    end else begin
      q = sx / sy;
      r = sx % sy;
      v.hi = r[31:0]; v.lo = q[31:0];
    end
    return v;
  endfunction
  task automatic issue(input vec_t v);
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    sb.push_back(v);
    chk("busy_after_accept", busy, 1);
    chk("dz_cleared_at_accept", dz, 0);
    chk("done_low_after_accept", done, 0);
  endtask
  task automatic finish_op(input string tag, input bit poke);
    int lat = 0;
    vec_t e;
    while (!done && lat < 100) begin
      if (poke && lat < W - 4) begin
        start = lat[0]; op = 2'($urandom); a = $urandom; b = $urandom;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, lat, W + 1);
    chk({tag, "_busy_with_done"}, busy, 0);
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s_scoreboard: got done, expected no result pending", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_hi"}, hi, e.hi);
      chk({tag, "_lo"}, lo, e.lo);
      chk({tag, "_divByZero"}, dz, e.dz);
    end
  endtask
  initial begin
    bit saw;
    int lat;
    logic [1:0] o;
    logic [W-1:0] x, y;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_dz", dz, 0);
    vecs.push_back('{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0});
    vecs.push_back('{2'd1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0});
    vecs.push_back('{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
    vecs.push_back('{2'd2, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0});
    vecs.push_back('{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0});
    vecs.push_back('{2'd2, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1});
    vecs.push_back('{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0});
    vecs.push_back('{2'd3, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1});
    vecs.push_back('{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0});
    repeat (8) begin
      o = 2'($urandom); x = $urandom; y = $urandom;
      if (o[1] && $urandom_range(0, 3) == 0) y = '0;
      vecs.push_back(model(o, x, y));
    end
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i]);
      finish_op($sformatf("vec%0d", i), i == 1 || i == 10);
      if (i % 4 == 3) repeat (2) @(posedge clk);
      #0;
    end
    issue(vecs[0]);
    finish_op("pre_abort", 1'b0);
    issue(vecs[0]);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    sb.delete();
    saw = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done) saw = 1'b1;
    end
    chk("abort_no_done", saw, 0);
    issue(vecs[3]);
    finish_op("recover", 1'b0);
    t8[0] = '{2'd1, 8'h80, 8'h80, 8'h40, 8'h00};
    t8[1] = '{2'd3, 8'h80, 8'hFF, 8'h00, 8'h80};
    t8[2] = '{2'd2, 8'hFF, 8'h10, 8'h0F, 8'h0F};
    for (int i = 0; i < 3; i++) begin
      op8 = t8[i].op; a8 = t8[i].a; b8 = t8[i].b; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      lat = 0;
      while (!done8 && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("w8_%0d_latency", i), lat, 9);
      chk($sformatf("w8_%0d_hi", i), {24'b0, hi8}, {24'b0, t8[i].hi});
      chk($sformatf("w8_%0d_lo", i), {24'b0, lo8}, {24'b0, t8[i].lo});
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
